mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 2, meaning number of core-side AXI4-Lite master ports (legal 1..8).
REQ-002 The block SHALL have parameters ADDR_WIDTH, default `AXI_ADDR_WIDTH (32), and DATA_WIDTH, default `AXI_DATA_WIDTH (32), meaning AXI address and data widths; STRB width = DATA_WIDTH/8.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port RSTn  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have ports S_AXI_<sig>  direction per AXI4-Lite slave role  NUM_MASTERS*width(sig)  one packed lane per core; lane i occupies bits [(i+1)*w-1 : i*w]; sig covers AWVALID/AWREADY/AWADDR/AWPROT/WVALID/WREADY/WDATA/WSTRB/BVALID/BREADY/BRESP/ARVALID/ARREADY/ARADDR/ARPROT/RVALID/RREADY/RDATA/RRESP.
REQ-006 The block SHALL have ports M_AXI_<sig>  direction per AXI4-Lite master role  width(sig)  single shared memory port, same signal set.
REQ-007 The block SHALL have port grant  output  NUM_MASTERS  one-hot index of the lane owning the memory port, all-zero in IDLE.
REQ-008 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-009 The block SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP, with exactly one transaction outstanding on M_AXI at any time.
REQ-010 Lane i SHALL request when S_AXI_ARVALID[i] or (S_AXI_AWVALID[i] and S_AXI_WVALID[i]) is high.
REQ-011 In IDLE, with any request present, the FSM SHALL register the grant for the first requesting lane found searching upward from priority pointer ptr, wrapping NUM_MASTERS-1 to 0, and leave IDLE on the next edge.
REQ-012 If the granted lane requests both read and write, the write SHALL win (next state WR_XFER); otherwise the state SHALL be RD_ADDR or WR_XFER per the request.
REQ-013 In RD_ADDR, M_AXI_ARVALID/ARADDR/ARPROT SHALL equal the granted lane's signals, S_AXI_ARREADY[g] SHALL equal M_AXI_ARREADY, and the handshake SHALL move the FSM to RD_DATA.
REQ-014 In RD_DATA, M_AXI_RREADY SHALL equal S_AXI_RREADY[g]; RVALID/RDATA/RRESP SHALL reach lane g only; the R handshake SHALL return the FSM to IDLE.
REQ-015 In WR_XFER, AW and W SHALL be forwarded from lane g independently; internal flags aw_done and w_done SHALL set on their handshakes and gate further M_AXI_AWVALID/WVALID; when both are done (same or different cycles) the FSM SHALL enter WR_RESP.
REQ-016 In WR_RESP, M_AXI_BREADY SHALL equal S_AXI_BREADY[g]; B goes to lane g only; the B handshake SHALL return the FSM to IDLE.
REQ-017 On every return to IDLE, ptr SHALL become (g+1) mod NUM_MASTERS; ptr SHALL not change otherwise.
REQ-018 Non-granted lanes SHALL see all READY and VALID outputs low; in IDLE all M_AXI VALID and READY outputs SHALL be low.
REQ-019 Minimum read latency SHALL be: request seen in IDLE cycle 0, M_AXI_ARVALID high cycle 1; a new grant is possible the cycle after the R handshake.
REQ-020 A requesting lane SHALL be granted within NUM_MASTERS transactions (no starvation).
REQ-021 With NUM_MASTERS=1 the block SHALL behave as a pass-through with one IDLE bubble between transactions.

Reset
REQ-022 While RSTn is low, state SHALL be IDLE, ptr 0, grant 0, busy 0, aw_done/w_done 0, and every VALID/READY output on both sides 0, independent of CLK.
REQ-023 Reset asserted mid-transaction SHALL abandon it without issuing any response to the core lane; data outputs are don't-care.

Verification
REQ-024 Single read: lane 1 ARADDR=0x0000_0010, memory RDATA=0xDEAD_BEEF -> M_ARADDR=0x10 on cycle 1, lane 1 receives 0xDEADBEEF, RRESP=0, grant=2'b10 then 0.
REQ-025 Contention: lanes 0 and 1 both read continuously, ptr=0 -> grants alternate 0,1,0,1 across four transactions.
REQ-026 Write with skew: lane 0 AWADDR=0x20, memory AWREADY at cycle 1 and WREADY at cycle 3 -> each handshake occurs once, WR_RESP entered after cycle 3, BRESP=0 reaches lane 0 only.
REQ-027 Lane 2 (NUM_MASTERS=4) asserts ARVALID and AW+WVALID together -> write performed first, read on a later grant.
REQ-028 RSTn pulsed low during RD_DATA -> outputs zero asynchronously, busy=0; after release, lane 0 request granted with ptr=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one AXI4-Lite memory port among several core lanes
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
module mem_port_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH
) (
  input  logic                                  CLK,
  input  logic                                  RSTn,
  input  logic [NUM_MASTERS-1:0]                S_AXI_AWVALID,
  output logic [NUM_MASTERS-1:0]                S_AXI_AWREADY,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [NUM_MASTERS*3-1:0]              S_AXI_AWPROT,
  input  logic [NUM_MASTERS-1:0]                S_AXI_WVALID,
  output logic [NUM_MASTERS-1:0]                S_AXI_WREADY,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  output logic [NUM_MASTERS-1:0]                S_AXI_BVALID,
  input  logic [NUM_MASTERS-1:0]                S_AXI_BREADY,
  output logic [NUM_MASTERS*2-1:0]              S_AXI_BRESP,
  input  logic [NUM_MASTERS-1:0]                S_AXI_ARVALID,
  output logic [NUM_MASTERS-1:0]                S_AXI_ARREADY,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [NUM_MASTERS*3-1:0]              S_AXI_ARPROT,
  output logic [NUM_MASTERS-1:0]                S_AXI_RVALID,
  input  logic [NUM_MASTERS-1:0]                S_AXI_RREADY,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [NUM_MASTERS*2-1:0]              S_AXI_RRESP,
  output logic                                  M_AXI_AWVALID,
  input  logic                                  M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0]                 M_AXI_AWADDR,
  output logic [2:0]                            M_AXI_AWPROT,
  output logic                                  M_AXI_WVALID,
  input  logic                                  M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0]                 M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]               M_AXI_WSTRB,
  input  logic                                  M_AXI_BVALID,
  output logic                                  M_AXI_BREADY,
  input  logic [1:0]                            M_AXI_BRESP,
  output logic                                  M_AXI_ARVALID,
  input  logic                                  M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0]                 M_AXI_ARADDR,
  output logic [2:0]                            M_AXI_ARPROT,
  input  logic                                  M_AXI_RVALID,
  output logic                                  M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0]                 M_AXI_RDATA,
  input  logic [1:0]                            M_AXI_RRESP,
  output logic [NUM_MASTERS-1:0]                grant,
  output logic                                  busy
);
  localparam int N  = NUM_MASTERS;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP} state_t;
  state_t state, state_d;
  logic [IW-1:0] ptr, g, sel, g_next, cand;
  logic [IW:0] sum;
  logic [N-1:0] req, wr_req;
  logic aw_done, w_done, aw_hs, w_hs;
  int gi;
  assign wr_req = S_AXI_AWVALID & S_AXI_WVALID;
  assign req = S_AXI_ARVALID | wr_req;
  assign gi = int'(g);
  assign g_next = (g == IW'(N - 1)) ? '0 : g + 1'b1;
  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs = M_AXI_WVALID & M_AXI_WREADY;
  assign busy = state != IDLE;
  assign grant = busy ? N'(1) << g : '0;
  // first requesting lane at or above ptr, wrapping; lowest offset wins
  always_comb begin
    sel = ptr;
    sum = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (req[cand]) sel = cand;
    end
  end
  // next state and lane/memory routing; only the granted lane ever sees VALID/READY
  always_comb begin
    state_d = state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID = 1'b0;
    M_AXI_BREADY = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY = 1'b0;
    M_AXI_AWADDR = S_AXI_AWADDR[gi*AW +: AW];
    M_AXI_AWPROT = S_AXI_AWPROT[gi*3 +: 3];
    M_AXI_WDATA = S_AXI_WDATA[gi*DW +: DW];
    M_AXI_WSTRB = S_AXI_WSTRB[gi*SW +: SW];
    M_AXI_ARADDR = S_AXI_ARADDR[gi*AW +: AW];
    M_AXI_ARPROT = S_AXI_ARPROT[gi*3 +: 3];
    S_AXI_AWREADY = '0;
    S_AXI_WREADY = '0;
    S_AXI_BVALID = '0;
    S_AXI_ARREADY = '0;
    S_AXI_RVALID = '0;
    S_AXI_BRESP = '0;
    S_AXI_RRESP = '0;
    S_AXI_RDATA = '0;
    S_AXI_BRESP[gi*2 +: 2] = M_AXI_BRESP;
    S_AXI_RRESP[gi*2 +: 2] = M_AXI_RRESP;
    S_AXI_RDATA[gi*DW +: DW] = M_AXI_RDATA;
    case (state)
      IDLE: if (|req) state_d = wr_req[sel] ? WR_XFER : RD_ADDR;
      RD_ADDR: begin
        M_AXI_ARVALID = S_AXI_ARVALID[g];
        S_AXI_ARREADY[g] = M_AXI_ARREADY;
        if (M_AXI_ARVALID & M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        M_AXI_RREADY = S_AXI_RREADY[g];
        S_AXI_RVALID[g] = M_AXI_RVALID;
        if (M_AXI_RVALID & M_AXI_RREADY) state_d = IDLE;
      end
      WR_XFER: begin
        M_AXI_AWVALID = S_AXI_AWVALID[g] & ~aw_done;
        M_AXI_WVALID = S_AXI_WVALID[g] & ~w_done;
        S_AXI_AWREADY[g] = M_AXI_AWREADY & ~aw_done;
        S_AXI_WREADY[g] = M_AXI_WREADY & ~w_done;
        if ((aw_done | (M_AXI_AWVALID & M_AXI_AWREADY)) & (w_done | (M_AXI_WVALID & M_AXI_WREADY))) state_d = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_BREADY = S_AXI_BREADY[g];
        S_AXI_BVALID[g] = M_AXI_BVALID;
        if (M_AXI_BVALID & M_AXI_BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, grant index, write-channel completion flags and round-robin pointer
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE) begin
        g <= sel;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (state == WR_XFER) begin
        aw_done <= aw_done | aw_hs;
        w_done <= w_done | w_hs;
      end
      if (state != IDLE && state_d == IDLE) ptr <= g_next;
    end
  end
endmodule
